// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: one-hot grant, address-phase owner ID and lock flag,
// with a per-tenure beat budget that preempts unlocked owners.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic                   hmastlock,
  output logic [1:0]             dbg_state_o,
  output logic [7:0]             dbg_hold_cnt_o
);

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [1:0] DEF_ID     = 2'(DEFAULT_MASTER);
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_e                   state_q, state_d;
  logic [1:0]               gnt_id_q, gnt_d;
  logic [7:0]               hold_cnt_q, hold_cnt_d;
  logic [1:0]               hmaster_q;
  logic                     hmastlock_q;
  logic [NUM_MASTERS-1:0]   hgrant_q;

  logic [3:0] req_ext, lock_ext;
  logic [1:0] winner, idx;
  logic       found, others_req, preempt_due, boundary;

  // Round-robin search starting after the current owner; the owner is checked last.
  always_comb begin
    req_ext  = '0;
    lock_ext = '0;
    req_ext[NUM_MASTERS-1:0]  = hbusreq;
    lock_ext[NUM_MASTERS-1:0] = hlock;
    found  = 1'b0;
    winner = DEF_ID;
    idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = 2'((int'(gnt_id_q) + k) % NUM_MASTERS);
      if (!found && req_ext[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    others_req  = |(req_ext & ~(4'b0001 << gnt_id_q));
    preempt_due = (hold_cnt_q >= MAX_HOLD_C) && others_req && (state_q != LOCKED);
    boundary    = (htrans == 2'b00) || !req_ext[gnt_id_q] || preempt_due;
  end

  // A lock request takes priority over any arbitration due in the same cycle.
  always_comb begin
    gnt_d   = gnt_id_q;
    state_d = state_q;
    case (state_q)
      LOCKED: begin
        if (!lock_ext[gnt_id_q]) state_d = OWNED;
      end
      OWNED: begin
        if (lock_ext[gnt_id_q]) begin
          state_d = LOCKED;
        end else if (boundary) begin
          gnt_d   = found ? winner : DEF_ID;
          state_d = found ? OWNED : PARK;
        end
      end
      default: begin
        if (boundary) begin
          gnt_d   = found ? winner : DEF_ID;
          state_d = found ? OWNED : PARK;
        end
      end
    endcase
    if (gnt_d != gnt_id_q) begin
      hold_cnt_d = '0;
    end else if (htrans[1] && (hold_cnt_q < MAX_HOLD_C)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Every piece of state advances only on hready=1; wait states freeze the arbiter.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= PARK;
      gnt_id_q    <= DEF_ID;
      hold_cnt_q  <= '0;
      hmaster_q   <= DEF_ID;
      hmastlock_q <= 1'b0;
      hgrant_q    <= NUM_MASTERS'(1) << DEF_ID;
    end else if (hready) begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hmaster_q   <= gnt_id_q;
      hmastlock_q <= (state_q == LOCKED);
      hgrant_q    <= NUM_MASTERS'(1) << gnt_d;
    end
  end

  assign hgrant         = hgrant_q;
  assign hmaster        = hmaster_q;
  assign hmastlock      = hmastlock_q;
  assign dbg_state_o    = state_q;
  assign dbg_hold_cnt_o = hold_cnt_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_ahb_bus_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 16;
  localparam int DEFM = 0;
  localparam int W    = 15;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  logic         hclk    = 1'b0;
  logic         hreset  = 1'b1;
  logic [N-1:0] hbusreq = '0;
  logic [N-1:0] hlock   = '0;
  logic [1:0]   htrans  = IDLE;
  logic         hready  = 1'b1;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;
  logic [1:0]   dbg_state;
  logic [7:0]   dbg_hold;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAXH), .DEFAULT_MASTER(DEFM)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmastlock(hmastlock), .dbg_state_o(dbg_state), .dbg_hold_cnt_o(dbg_hold)
  );

  // ---------------- clock ----------------
  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cmp_e;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Owner, whether the bus is parked / locked, and beats used in the current tenure.
  int m_owner, m_beats, m_addr_owner, m_next;
  bit m_parked, m_locked, m_addr_locked, m_others, m_bound, m_arb;

  always @(posedge hclk) begin
    if (hreset) begin
      m_owner = DEFM; m_beats = 0; m_addr_owner = DEFM;
      m_parked = 1; m_locked = 0; m_addr_locked = 0;
    end else if (hready) begin
      m_others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && hbusreq[i]) m_others = 1;
      m_bound = (htrans == IDLE) || !hbusreq[m_owner] ||
                (m_beats >= MAXH && m_others && !m_locked);
      m_addr_owner  = m_owner;
      m_addr_locked = m_locked;
      m_next = m_owner;
      m_arb  = 0;
      if (m_locked) begin
        if (!hlock[m_owner]) m_locked = 0;
      end else if (!m_parked && hlock[m_owner]) begin
        m_locked = 1;
      end else if (m_bound) begin
        m_arb = 1;
      end
      if (m_arb) begin
        m_next = -1;
        for (int k = 1; k <= N; k++)
          if (m_next < 0 && hbusreq[(m_owner + k) % N]) m_next = (m_owner + k) % N;
        m_parked = (m_next < 0);
        if (m_next < 0) m_next = DEFM;
      end
      if (m_next != m_owner) m_beats = 0;
      else if (htrans[1] && m_beats < MAXH) m_beats++;
      m_owner = m_next;
    end
    exp_q.push_back({4'(1 << m_owner), 2'(m_addr_owner), m_addr_locked, 8'(m_beats)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      n_checks++;
      if ({hgrant, hmaster, hmastlock, dbg_hold} === cmp_e) n_pass++;
      else $display("FAIL cycle_cmp t=%0t: got grant=%b hmaster=%0d lock=%b hold=%0d, expected grant=%b hmaster=%0d lock=%b hold=%0d",
                    $time, hgrant, hmaster, hmastlock, dbg_hold,
                    cmp_e[14:11], cmp_e[10:9], cmp_e[8], cmp_e[7:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge hclk);
  endtask

  logic [N-1:0] blk_req, blk_lock;
  int           blk_mode;

  initial begin
    // Reset with every master requesting.
    hbusreq = '1;
    cyc(2);
    chk("reset_hgrant", int'(hgrant), 1);
    chk("reset_hmaster", int'(hmaster), 0);
    chk("reset_hmastlock", int'(hmastlock), 0);
    chk("reset_hold", int'(dbg_hold), 0);

    // Single request from master 2.
    hreset = 0; hbusreq = 4'b0100; htrans = IDLE; hready = 1;
    cyc(1);
    chk("single_hgrant", int'(hgrant), 4);
    chk("single_hmaster_lag", int'(hmaster), 0);
    cyc(1);
    chk("single_hmaster", int'(hmaster), 2);
    hbusreq = 4'b0000;
    cyc(1);
    chk("single_drop_hgrant", int'(hgrant), 1);

    // Beat budget: master 1 streams, master 2 joins after three beats.
    hbusreq = 4'b0010; htrans = IDLE;
    cyc(1);
    chk("budget_owner", int'(hgrant), 2);
    for (int b = 1; b <= 17; b++) begin
      htrans  = (b == 1) ? NONSEQ : SEQ;
      hbusreq = (b > 3) ? 4'b0110 : 4'b0010;
      cyc(1);
      if (b == 16) begin
        chk("budget_hold16_grant", int'(hgrant), 2);
        chk("budget_hold16_cnt", int'(dbg_hold), 16);
      end
    end
    chk("budget_preempt_grant", int'(hgrant), 4);
    chk("budget_preempt_cnt", int'(dbg_hold), 0);

    // Lock: master 1 locks and streams 40 beats while master 2 waits.
    hbusreq = 4'b0010; htrans = IDLE;
    cyc(1);
    chk("lock_owner", int'(hgrant), 2);
    hbusreq = 4'b0110; hlock = 4'b0010;
    for (int b = 1; b <= 40; b++) begin
      htrans = (b == 1) ? NONSEQ : SEQ;
      cyc(1);
    end
    chk("lock_hold_grant", int'(hgrant), 2);
    chk("lock_hmastlock", int'(hmastlock), 1);
    hlock = 4'b0000;
    cyc(1);
    chk("unlock_grant_kept", int'(hgrant), 2);
    cyc(1);
    chk("unlock_grant_moves", int'(hgrant), 4);
    chk("unlock_hmastlock", int'(hmastlock), 0);

    // Wait states with a pending grant change to master 1.
    hbusreq = 4'b0010; htrans = IDLE; hready = 0;
    for (int w = 0; w < 5; w++) begin
      cyc(1);
      chk("wait_hmaster", int'(hmaster), 1);
      chk("wait_hgrant", int'(hgrant), 4);
    end
    hready = 1;
    cyc(1);
    chk("wait_release_hmaster", int'(hmaster), 2);
    chk("wait_release_hgrant", int'(hgrant), 2);

    // Randomized traffic in 20-cycle blocks: free-running or sticky streaming.
    for (int blk = 0; blk < 200; blk++) begin
      blk_mode = $urandom_range(0, 2);
      blk_req  = N'($urandom_range(0, 15));
      blk_lock = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      for (int c = 0; c < 20; c++) begin
        hreset = ($urandom_range(0, 299) == 0);
        hready = ($urandom_range(0, 3) != 0);
        if (blk_mode == 0) begin
          hbusreq = N'($urandom_range(0, 15));
          hlock   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
          htrans  = 2'($urandom_range(0, 3));
        end else begin
          hbusreq = blk_req;
          hlock   = (c < 12) ? blk_lock : '0;
          htrans  = ($urandom_range(0, 1) == 0) ? NONSEQ : SEQ;
        end
        cyc(1);
      end
    end

    hreset = 0; hready = 1; hbusreq = '0; hlock = '0; htrans = IDLE;
    cyc(2);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
